// File: rtl/output_port_arbiter_mux.sv
// output_port_arbiter_mux
//   Per-output-port packet arbiter. Round-robins among NUM_PORTS ingress
//   channels, holds the grant for a whole packet (until an accepted beat
//   with last=1), and drives one registered egress beat with valid/ready.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_last    per-channel beat valid / end-of-packet
//   in_data             flattened beats, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready            per-channel accept, one-hot or zero
//   out_data/out_last   registered egress beat
//   out_valid/out_ready egress handshake
//   grant_sel           locked channel index, 0 while idle
//   busy                high while a packet is locked

// Per-channel slice: ready gating and zero-masking of the beat so the
// top can OR-reduce all lanes into the selected beat.
module output_port_arbiter_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  lane_grant,   // this channel holds the lock
  input  logic                  can_take,     // output register can take a beat
  input  logic                  lane_valid,
  input  logic [DATA_WIDTH-1:0] lane_data,
  input  logic                  lane_last,
  output logic                  lane_ready,
  output logic                  lane_acc,
  output logic [DATA_WIDTH-1:0] lane_data_m,
  output logic                  lane_last_m
);
  assign lane_ready  = lane_grant & can_take;
  assign lane_acc    = lane_ready & lane_valid;
  assign lane_data_m = lane_grant ? lane_data : '0;
  assign lane_last_m = lane_grant & lane_last;
endmodule

module output_port_arbiter_mux #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_last,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SEL_WIDTH-1:0]            grant_sel,
  output logic                            busy
);
  typedef enum logic {IDLE, LOCKED} state_t;

  // Index arithmetic carries one extra bit so ptr+offset never overflows
  // before the modulo fold.
  localparam logic [SEL_WIDTH:0] NP_W = (SEL_WIDTH+1)'(NUM_PORTS);

  state_t                              state_q, state_d;
  logic [SEL_WIDTH-1:0]                grant_q, grant_d;
  logic [SEL_WIDTH-1:0]                rr_ptr_q, rr_ptr_d;
  logic [SEL_WIDTH-1:0]                pick;
  logic [SEL_WIDTH:0]                  off, sum, nxt;
  logic [2*NUM_PORTS-1:0]              req2;
  logic                                any_req;

  logic [NUM_PORTS-1:0]                lane_grant, lane_acc, lane_last_m;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] lane_data_m;
  logic                                can_take, accept, sel_last;
  logic [DATA_WIDTH-1:0]               sel_data;

  assign can_take  = !out_valid || out_ready;
  assign busy      = (state_q == LOCKED);
  assign grant_sel = grant_q;
  assign any_req   = |in_valid;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    assign lane_grant[i] = (state_q == LOCKED) && (grant_q == SEL_WIDTH'(i));
    output_port_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .lane_grant  (lane_grant[i]),
      .can_take    (can_take),
      .lane_valid  (in_valid[i]),
      .lane_data   (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .lane_last   (in_last[i]),
      .lane_ready  (in_ready[i]),
      .lane_acc    (lane_acc[i]),
      .lane_data_m (lane_data_m[i]),
      .lane_last_m (lane_last_m[i])
    );
  end

  // At most one lane is granted, so OR-reduction is the mux.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_data = sel_data | lane_data_m[i];
      sel_last = sel_last | lane_last_m[i];
    end
  end
  assign accept = |lane_acc;

  // Round-robin search: rotate requests so rr_ptr lands on bit 0, take the
  // lowest set bit (scan downward so the lowest offset is written last),
  // then fold ptr+offset back into 0..NUM_PORTS-1.
  always_comb begin
    req2 = {in_valid, in_valid} >> rr_ptr_q;
    off  = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--)
      if (req2[k]) off = (SEL_WIDTH+1)'(k);
    sum = {1'b0, rr_ptr_q} + off;
    if (sum >= NP_W) sum = sum - NP_W;
    pick = sum[SEL_WIDTH-1:0];
  end

  // Pointer after the current packet; non-power-of-two sizes wrap explicitly.
  always_comb begin
    nxt = {1'b0, grant_q} + (SEL_WIDTH+1)'(1);
    if (nxt >= NP_W) nxt = '0;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = LOCKED;
          grant_d = pick;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = nxt[SEL_WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Single-entry egress register. A new accept overwrites only when the
  // current beat is leaving (or absent), which is what can_take gates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_output_port_arbiter_mux.sv
// tb_output_port_arbiter_mux
//   Directed bench for output_port_arbiter_mux (NUM_PORTS=4 main instance,
//   NUM_PORTS=3 instance for the wrap case). A queue-based model of the
//   arbitration rules is compared against the DUT every cycle; directed
//   literal expectations pin egress order, latency and reset values.
module tb_output_port_arbiter_mux;
  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]    in_valid = '0, in_last = '0, in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic [DW-1:0]   out_data;
  logic          out_last, out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    grant_sel;
  logic          busy;

  logic [2:0]    v3 = '0, l3 = '0, r3;
  logic [47:0]   d3 = '0;
  logic [15:0]   od3;
  logic          ol3, ov3;
  logic          ordy3 = 1'b1;
  logic [1:0]    g3;
  logic          b3;

  output_port_arbiter_mux #(.NUM_PORTS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .grant_sel(grant_sel), .busy(busy)
  );

  output_port_arbiter_mux #(.NUM_PORTS(3), .DATA_WIDTH(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3),
    .in_last(l3), .in_ready(r3), .out_data(od3),
    .out_last(ol3), .out_valid(ov3), .out_ready(ordy3),
    .grant_sel(g3), .busy(b3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  bit            m_locked = 1'b0;
  int            m_grant = 0, m_ptr = 0;
  logic [16:0]   m_q[$];
  bit            m_full, m_pop, m_room, m_found;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_locked = 1'b0; m_grant = 0; m_ptr = 0; m_q.delete();
    end else begin
      m_full = (m_q.size() != 0);
      m_pop  = m_full && out_ready;
      m_room = !m_full || out_ready;
      if (m_pop) void'(m_q.pop_front());
      if (m_locked) begin
        if (in_valid[m_grant] && m_room) begin
          m_q.push_back({in_last[m_grant], in_data[m_grant*DW +: DW]});
          if (in_last[m_grant]) begin
            m_ptr = (m_grant + 1) % N;
            m_locked = 1'b0;
            m_grant = 0;
          end
        end
      end else if (in_valid != '0) begin
        m_found = 1'b0;
        for (int k = 0; k < N; k++)
          if (!m_found && in_valid[(m_ptr + k) % N]) begin
            m_grant = (m_ptr + k) % N;
            m_found = 1'b1;
          end
        m_locked = 1'b1;
      end
    end
  end

  // ---------------- compare + capture ----------------
  logic [N-1:0]  acc = '0;
  logic [N-1:0]  exp_rdy;
  logic [15:0]   eg_data[$];
  bit            eg_last[$];
  int            eg_cyc[$];
  int            last_grant = -1, busy_fall_cyc = -1;
  bit            busy_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    acc = in_valid & in_ready;
    if (out_valid && out_ready) begin
      eg_data.push_back(out_data); eg_last.push_back(out_last); eg_cyc.push_back(cyc);
    end
    if (busy) last_grant = int'(grant_sel);
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(m_q[0][15:0]));
        chk("out_last", 32'(out_last), 32'(m_q[0][16]));
      end
      chk("busy", 32'(busy), 32'(m_locked));
      chk("grant_sel", 32'(grant_sel), m_grant);
      exp_rdy = (m_locked && (m_q.size() == 0 || out_ready)) ? N'(1 << m_grant) : '0;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    end
  end

  // ---------------- sources ----------------
  logic [16:0] src_mem[N][16];
  int          head[N], tail[N];

  task automatic clr();
    for (int c = 0; c < N; c++) begin head[c] = 0; tail[c] = 0; end
    eg_data.delete(); eg_last.delete(); eg_cyc.delete();
  endtask

  task automatic push(input int ch, input logic [15:0] d, input logic l);
    src_mem[ch][tail[ch]] = {l, d};
    tail[ch]++;
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (head[c] < tail[c]) begin
        in_valid[c] = 1'b1;
        in_data[c*DW +: DW] = src_mem[c][head[c]][15:0];
        in_last[c] = src_mem[c][head[c]][16];
      end else begin
        in_valid[c] = 1'b0;
        in_data[c*DW +: DW] = '0;
        in_last[c] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    for (int c = 0; c < N; c++)
      if (acc[c] && head[c] < tail[c]) head[c]++;
    drive();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  int c0;
  initial begin
    for (int c = 0; c < N; c++) begin head[c] = 0; tail[c] = 0; end

    // reset and idle
    step(); chk_en = 1'b1; step(); step();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_out_last",  32'(out_last), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_grant",     32'(grant_sel), 0);
    chk("rst_in_ready",  32'(in_ready), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (10) begin
      step(); @(negedge clk);
      chk("idle_out_valid", 32'(out_valid), 0);
      chk("idle_busy", 32'(busy), 0);
    end

    // single packet on channel 2
    clr();
    push(2, 16'hA001, 1'b0); push(2, 16'hA002, 1'b0); push(2, 16'hA003, 1'b1);
    step(); c0 = cyc;
    repeat (8) step();
    chk("t2_count", eg_data.size(), 3);
    for (int j = 0; j < 3 && j < eg_data.size(); j++) begin
      chk("t2_data", 32'(eg_data[j]), 32'(16'hA001 + 16'(j)));
      chk("t2_last", 32'(eg_last[j]), 32'(j == 2));
      chk("t2_lat",  eg_cyc[j] - c0, j + 2);
    end
    chk("t2_grant", last_grant, 2);
    chk("t2_busy_fall", busy_fall_cyc - c0, 4);

    // round robin with all channels requesting
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    clr();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < N; c++) begin
        push(c, 16'(c*4096 + p*256), 1'b0);
        push(c, 16'(c*4096 + p*256 + 1), 1'b1);
      end
    step();
    repeat (40) step();
    chk("t3_count", eg_data.size(), 16);
    for (int j = 0; j < 16 && j < eg_data.size(); j++) begin
      chk("t3_data", 32'(eg_data[j]), 32'(((j/2) % 4)*4096 + ((j/2)/4)*256 + (j % 2)));
      chk("t3_last", 32'(eg_last[j]), 32'(j % 2));
      if (j % 2 == 1) chk("t3_no_bubble", eg_cyc[j] - eg_cyc[j-1], 1);
    end

    // back-pressure on channel 1
    out_ready = 1'b0;
    clr();
    push(1, 16'h1111, 1'b0); push(1, 16'h2222, 1'b1);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      step(); @(negedge clk);
      chk("t4_hold_valid", 32'(out_valid), 1);
      chk("t4_hold_data",  32'(out_data), 32'h1111);
      chk("t4_hold_rdy",   32'(in_ready[1]), 0);
    end
    step(); out_ready = 1'b1;
    @(negedge clk);
    chk("t4_rdy_back", 32'(in_ready[1]), 1);
    step(); @(negedge clk);
    chk("t4_second_data", 32'(out_data), 32'h2222);
    chk("t4_second_last", 32'(out_last), 1);
    repeat (3) step();

    // mid-packet gap on channel 0 with channel 3 competing
    clr();
    push(0, 16'h0B01, 1'b0);
    step(); step();
    push(3, 16'h3C01, 1'b1);
    step(); step();
    @(negedge clk);
    chk("t5_gap_grant", 32'(grant_sel), 0);
    chk("t5_gap_busy",  32'(busy), 1);
    chk("t5_gap_rdy",   32'(in_ready), 32'h1);
    step();
    push(0, 16'h0B02, 1'b0); push(0, 16'h0B03, 1'b1);
    repeat (12) step();
    chk("t5_count", eg_data.size(), 4);
    if (eg_data.size() == 4) begin
      chk("t5_b0", 32'(eg_data[0]), 32'h0B01);
      chk("t5_b1", 32'(eg_data[1]), 32'h0B02);
      chk("t5_b2", 32'(eg_data[2]), 32'h0B03);
      chk("t5_b3", 32'(eg_data[3]), 32'h3C01);
    end

    // reset mid-packet
    clr();
    push(1, 16'h6A01, 1'b0); push(1, 16'h6A02, 1'b0); push(1, 16'h6A03, 1'b1);
    step(); step(); step();
    rst_n = 1'b0; clr();
    step(); @(negedge clk);
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_out_data",  32'(out_data), 0);
    chk("t6_out_last",  32'(out_last), 0);
    chk("t6_busy",      32'(busy), 0);
    chk("t6_grant",     32'(grant_sel), 0);
    chk("t6_in_ready",  32'(in_ready), 0);
    rst_n = 1'b1;
    repeat (3) step();

    // NUM_PORTS=3: grant 2 wraps the pointer to 0
    step();
    v3 = 3'b100; l3 = 3'b100; d3 = {16'h7C02, 16'h0, 16'h0};
    step(); @(negedge clk);
    chk("n3_grant2", 32'(g3), 2);
    chk("n3_rdy2",   32'(r3), 32'h4);
    step();
    v3 = 3'b011; l3 = 3'b011; d3 = {16'h0, 16'h7C01, 16'h7C00};
    @(negedge clk);
    chk("n3_out2",  32'(od3), 32'h7C02);
    chk("n3_ov2",   32'(ov3), 1);
    chk("n3_idle",  32'(b3), 0);
    step(); @(negedge clk);
    chk("n3_wrap_grant", 32'(g3), 0);
    chk("n3_wrap_busy",  32'(b3), 1);
    step();
    v3 = 3'b010;
    @(negedge clk);
    chk("n3_out0", 32'(od3), 32'h7C00);
    step(); @(negedge clk);
    chk("n3_grant1", 32'(g3), 1);
    v3 = '0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/output_port_arbiter_mux.md
Name: output_port_arbiter_mux

Overview:
- Parametrised successor to the switch's per-output-port 4:1 selector.
- Arbitrates among NUM_PORTS ingress channels with a round-robin policy and locks the grant for a whole packet (until a beat with last=1).
- Drives one registered egress stream with valid/ready back-pressure.
- One instance sits per output port, between the ingress FIFOs and the egress interface.

Parameters:
- NUM_PORTS, 4, number of ingress channels (2..16; need not be a power of two).
- DATA_WIDTH, 16, beat width in bits.
- SEL_WIDTH, $clog2(NUM_PORTS), width of the grant index.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  NUM_PORTS  per-channel beat valid.
- in_data  input  NUM_PORTS*DATA_WIDTH  flattened beats; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  input  NUM_PORTS  per-channel end-of-packet flag.
- in_ready  output  NUM_PORTS  per-channel accept; at most one bit high.
- out_data  output  DATA_WIDTH  registered egress beat.
- out_last  output  1  registered end-of-packet flag.
- out_valid  output  1  egress beat valid.
- out_ready  input  1  downstream accept.
- grant_sel  output  SEL_WIDTH  index of the locked channel; 0 when idle.
- busy  output  1  high while in LOCKED.

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, rr_ptr=0, grant_sel=0, busy=0, out_valid=0, out_data=0, out_last=0, in_ready=0.
- Reset asserted mid-packet: drop the packet, clear all state and outputs on that edge. No partial beat is held.
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - in_ready is all zero.
  - If any in_valid bit is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_PORTS.
  - Register that index into grant_sel and go to LOCKED next cycle.
  - If no bit is set, stay in IDLE.
- LOCKED:
  - in_ready[grant_sel] = (!out_valid || out_ready). All other in_ready bits are 0.
  - Accept occurs when in_valid[grant_sel] && in_ready[grant_sel].
  - On accept: register the selected channel's data and last into out_data/out_last and set out_valid=1.
- Output register:
  - If out_valid && out_ready and there is no new accept, clear out_valid next cycle.
  - While out_valid && !out_ready, out_data and out_last hold stable.
- Full-throughput: out_ready held high with continuous in_valid gives one beat per cycle, with no bubbles inside a packet.
- Latency:
  - First beat: in_valid rises in IDLE -> out_valid at cycle +2 (one cycle to arbitrate, one cycle to register).
  - Subsequent beats: 1 cycle.
- End of packet: an accepted beat with in_last=1 sends the FSM to IDLE next cycle and sets rr_ptr = (grant_sel+1) mod NUM_PORTS. With NUM_PORTS=3, grant 2 wraps to 0.
- Single-beat packets (first beat has last=1) are legal: LOCKED for exactly one accept.
- Granted channel drops in_valid mid-packet: stay LOCKED and wait. No other channel may interleave, and no beat is fabricated.
- Requests from non-granted channels never affect the current packet or rr_ptr.
- Re-arbitration happens in the IDLE cycle after the last beat is accepted. The last beat may still be waiting in the output register at that point; this is legal.
- Fairness: with all channels requesting continuously, grants rotate 0,1,2,3,0,… A channel waits at most NUM_PORTS-1 packets.
- The output register holds at most one beat, so the block never loses or duplicates a beat.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, then release with all in_valid=0 -> out_valid=0, busy=0, in_ready=0, grant_sel=0 for 10 cycles.
- Single packet, no back-pressure: channel 2 sends 3 beats 0xA001/0xA002/0xA003 (last on the third), out_ready=1 -> grant_sel=2; out_valid high on cycles +2..+4 with those values in order; out_last only on 0xA003; busy falls the cycle after the last accept.
- Round robin: all 4 channels request 2-beat packets continuously -> packet order on the egress is 0,1,2,3,0 with no interleaving of beats.
- Back-pressure: channel 1 packet 0x1111/0x2222, out_ready=0 for 4 cycles after the first beat -> out_data holds 0x1111, in_ready[1]=0 while the output is full; 0x2222 follows one cycle after out_ready=1.
- Mid-packet gap and a competing request: channel 0 drops in_valid for 3 cycles mid-packet while channel 3 requests -> grant stays 0, no channel-3 beat appears until channel 0's last beat is accepted, and channel 3 is granted next.
- Reset mid-packet and NUM_PORTS=3: assert rst_n=0 during a channel-1 packet -> all outputs return to reset values next edge. In a separate NUM_PORTS=3 build, a grant of channel 2 followed by requests from channels 0 and 1 grants channel 0.
